c499_ecc_encoder: RTL and testbench

Pipelined single-error-correcting encoder that produces the 8 check bits consumed by the c499 32-bit corrector. Accepts 32-bit data words over a valid/ready stream and emits 40-bit codewords. Any emitted codeword drives the corrector to zero syndrome when its enable input (N137) is 1. A one-shot single-bit error injector lets the bench exercise the corrector's correction paths.

---
 rtl/c499_ecc_encoder.sv | 199 +++++++++++++++++++
 tb/tb_c499_ecc_encoder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c499_ecc_encoder.sv
`timescale 1ns/1ps
// c499_ecc_encoder
// Two-stage pipelined encoder producing the 8 check bits read by the c499
// 32-bit single-error corrector, with a one-shot single-bit error injector.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     upstream word valid
//   in_ready     encoder can accept a word this cycle (combinational)
//   in_data      32-bit data word, bit i -> corrector input N(4i+1)
//   out_valid    codeword valid
//   out_ready    downstream accepts the codeword
//   out_data     data field, possibly with an injected flip
//   out_check    check bits, bit k -> corrector input N(129+k)
//   inj_arm      one-cycle pulse arming an injection
//   inj_pos      flip position sampled with inj_arm (0-31 data, 32-39 check)
//   inj_pending  an armed injection is waiting for a word
//   word_cnt     wrapping count of delivered codewords
module c499_ecc_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [7:0]  out_check,
  input  logic        inj_arm,
  input  logic [5:0]  inj_pos,
  output logic        inj_pending,
  output logic [15:0] word_cnt
);

  typedef enum logic [0:0] {StIdle, StArmed} inj_state_e;

  // Data bits covered by each check bit.
  function automatic logic [31:0] check_mask(input int unsigned k);
    logic [31:0] m;
    case (k)
      0:       m = 32'h00FF_1111;
      1:       m = 32'hFF00_2222;
      2:       m = 32'h0F0F_4444;
      3:       m = 32'hF0F0_8888;
      4:       m = 32'h1111_00FF;
      5:       m = 32'h2222_FF00;
      6:       m = 32'h4444_0F0F;
      default: m = 32'h8888_F0F0;
    endcase
    return m;
  endfunction

  // Stage 1
  logic        s1_valid_q;
  logic [31:0] s1_data_q;
  logic [31:0] s1_part_q;   // check k, byte lane g at bit 4k+g
  logic        s1_tag_q;
  logic [5:0]  s1_pos_q;

  // Stage 2
  logic        s2_valid_q;
  logic [31:0] s2_data_q;
  logic [7:0]  s2_check_q;

  logic [15:0] cnt_q;

  inj_state_e  state_q, state_d;
  logic [5:0]  arm_pos_q, arm_pos_d;

  logic        s2_load, s1_adv, s1_load, accept, tag_en;
  logic [31:0] part_d;
  logic [7:0]  check_d;
  logic [31:0] data_flip;
  logic [7:0]  check_flip;

  always_comb begin
    s2_load = !s2_valid_q || out_ready;
    s1_adv  = s1_valid_q && s2_load;
    s1_load = !s1_valid_q || s1_adv;
    accept  = in_valid && s1_load;
  end

  // Byte-lane partial parities, reduced to check bits in stage 2.
  always_comb begin
    logic [31:0] masked;
    part_d = '0;
    masked = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      masked = in_data & check_mask(k);
      for (int unsigned g = 0; g < 4; g++) begin
        part_d[4*k+g] = ^masked[8*g +: 8];
      end
    end
  end

  always_comb begin
    check_d = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      check_d[k] = ^s1_part_q[4*k +: 4];
    end
  end

  // Positions 40-63 consume the injection without flipping anything.
  always_comb begin
    data_flip  = '0;
    check_flip = '0;
    if (s1_tag_q) begin
      if (!s1_pos_q[5]) begin
        data_flip[s1_pos_q[4:0]] = 1'b1;
      end else if (s1_pos_q[4:3] == 2'b00) begin
        check_flip[s1_pos_q[2:0]] = 1'b1;
      end
    end
  end

  // Injection FSM. A new arm always wins over consumption, so an arm in the
  // same cycle as an accept stays pending for the following word.
  always_comb begin
    state_d   = state_q;
    arm_pos_d = arm_pos_q;
    tag_en    = 1'b0;
    case (state_q)
      StIdle: begin
        if (inj_arm) begin
          state_d   = StArmed;
          arm_pos_d = inj_pos;
        end
      end
      StArmed: begin
        tag_en = 1'b1;
        if (inj_arm) begin
          arm_pos_d = inj_pos;
        end else if (accept) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      arm_pos_q <= '0;
    end else begin
      state_q   <= state_d;
      arm_pos_q <= arm_pos_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_part_q  <= '0;
      s1_tag_q   <= 1'b0;
      s1_pos_q   <= '0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (accept) begin
        s1_data_q <= in_data;
        s1_part_q <= part_d;
        s1_tag_q  <= tag_en;
        s1_pos_q  <= arm_pos_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_check_q <= '0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q  <= s1_data_q ^ data_flip;
        s2_check_q <= check_d ^ check_flip;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (s2_valid_q && out_ready) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign in_ready    = s1_load;
  assign out_valid   = s2_valid_q;
  assign out_data    = s2_data_q;
  assign out_check   = s2_check_q;
  assign inj_pending = (state_q == StArmed);
  assign word_cnt    = cnt_q;

endmodule

// File: tb/tb_c499_ecc_encoder.sv
`timescale 1ns/1ps
// Testbench for c499_ecc_encoder: directed vectors, backpressure stream,
// injection, corrector loopback, mid-stream reset and counter wrap.
module tb_c499_ecc_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_check;
  logic        inj_arm;
  logic [5:0]  inj_pos;
  logic        inj_pending;
  logic [15:0] word_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  c499_ecc_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_check   (out_check),
    .inj_arm     (inj_arm),
    .inj_pos     (inj_pos),
    .inj_pending (inj_pending),
    .word_cnt    (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Column of the parity-check matrix for data bit i, derived from the nibble
  // structure of the check equations.
  function automatic logic [7:0] col(input int i);
    int j, b;
    logic [7:0] c;
    j = i / 4;
    b = i % 4;
    c = '0;
    if (j < 4) begin
      c[b] = 1'b1;
      c[4 + ((j >> 1) & 1)] = 1'b1;
      c[6 + (j & 1)] = 1'b1;
    end else begin
      c[4 + b] = 1'b1;
      c[(j >> 1) & 1] = 1'b1;
      c[2 + (j & 1)] = 1'b1;
    end
    return c;
  endfunction

  function automatic logic [7:0] enc(input logic [31:0] d);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) if (d[i]) c ^= col(i);
    return c;
  endfunction

  // c499 corrector behaviour with N137=1.
  function automatic logic [31:0] corr(input logic [31:0] d, input logic [7:0] c);
    logic [7:0]  s;
    logic [31:0] r;
    s = c ^ enc(d);
    r = d;
    for (int i = 0; i < 32; i++) if (s == col(i)) r[i] = ~r[i];
    return r;
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    inj_arm   = 1'b0;
    inj_pos   = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Presents a word for one edge, then waits one more edge so it is on the output.
  task automatic send_word(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic arm(input logic [5:0] p);
    inj_arm = 1'b1;
    inj_pos = p;
    tick();
    inj_arm = 1'b0;
  endtask

  logic [31:0] w [8];
  logic [31:0] d, r;
  logic [5:0]  p;
  int sent, rcv, occ;
  logic acc, dlv;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    inj_arm   = 1'b0;
    inj_pos   = '0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_check", out_check, 0);
    chk("rst_inj_pending", inj_pending, 0);
    chk("rst_word_cnt", word_cnt, 0);
    do_reset();

    // Directed words
    send_word(32'h0000_0000);
    chk("dir0_valid", out_valid, 1);
    chk("dir0_check", out_check, 8'h00);
    send_word(32'h0000_0001);
    chk("dir1_check", out_check, 8'h51);
    chk("dir1_data", out_data, 32'h0000_0001);
    send_word(32'h8000_0000);
    chk("dir2_check", out_check, 8'h8A);
    send_word(32'hFFFF_FFFF);
    chk("dir3_check", out_check, 8'h00);
    chk("dir3_data", out_data, 32'hFFFF_FFFF);

    // Injection
    arm(6'd5);
    chk("inj_pending_armed", inj_pending, 1);
    in_valid = 1'b1;
    in_data  = 32'h0;
    tick();
    in_valid = 1'b0;
    chk("inj_pending_fall", inj_pending, 0);
    tick();
    chk("inj5_data", out_data, 32'h0000_0020);
    chk("inj5_check", out_check, 8'h00);
    send_word(32'h0);
    chk("inj_next_clean", out_data, 32'h0);
    arm(6'd35);
    send_word(32'h0000_0001);
    chk("inj35_check", out_check, 8'h59);
    chk("inj35_data", out_data, 32'h0000_0001);
    arm(6'd50);
    send_word(32'hFFFF_FFFF);
    chk("inj50_data", out_data, 32'hFFFF_FFFF);
    chk("inj50_check", out_check, 8'h00);
    chk("inj50_consumed", inj_pending, 0);
    arm(6'd3);
    arm(6'd7);
    send_word(32'h0);
    chk("inj_overwrite", out_data, 32'h0000_0080);

    // Stream with backpressure
    do_reset();
    w = '{32'h0000_0001, 32'h8000_0000, 32'hDEAD_BEEF, 32'h1234_5678,
          32'hFFFF_0000, 32'h0F0F_0F0F, 32'hA5A5_5A5A, 32'h0000_FFFF};
    sent = 0;
    rcv  = 0;
    occ  = 0;
    for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
      in_valid  = (sent < 8);
      in_data   = (sent < 8) ? w[sent] : 32'h0;
      out_ready = !(cyc >= 3 && cyc <= 6);
      #1;
      chk("bp_in_ready", in_ready, ((occ < 2) || out_ready));
      if (occ == 2) chk("bp_out_valid", out_valid, 1);
      if (out_valid) begin
        chk("bp_order_data", out_data, w[rcv]);
        chk("bp_order_check", out_check, enc(w[rcv]));
      end
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        occ++;
      end
      if (dlv) begin
        rcv++;
        occ--;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_all_received", rcv, 8);
    chk("bp_word_cnt", word_cnt, 16'd8);
    chk("bp_drained", out_valid, 0);

    // Corrector loopback
    for (int i = 0; i < 1000; i++) begin
      d = $urandom;
      p = 6'($urandom_range(0, 39));
      arm(p);
      send_word(d);
      r = corr(out_data, out_check);
      chk("loop_corrected", r, d);
    end
    for (int i = 0; i < 50; i++) begin
      d = $urandom;
      send_word(d);
      chk("loop_clean_check", out_check, enc(d));
      chk("loop_clean_corr", corr(out_data, out_check), d);
    end

    // Reset mid-stream with both stages full and injection armed
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0003;
    tick();
    in_data = 32'h0000_0004;
    tick();
    in_valid = 1'b0;
    chk("mid_full_in_ready", in_ready, 0);
    arm(6'd9);
    chk("mid_armed", inj_pending, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_inj_pending", inj_pending, 0);
    chk("mid_rst_word_cnt", word_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0001;
    tick();
    in_valid = 1'b0;
    chk("lat_edge1_invalid", out_valid, 0);
    tick();
    chk("lat_edge2_valid", out_valid, 1);
    chk("lat_edge2_check", out_check, 8'h51);
    chk("lat_edge2_data", out_data, 32'h0000_0001);

    // Counter wrap
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      in_data = i;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("wrap_word_cnt", word_cnt, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
